// File: rtl/z480_pkg.sv
// Shared Z480 vector-pipeline types: issue-queue entry layout and default sizing.
package z480_pkg;
  localparam int VEC_IQ_DEPTH     = 4;
  localparam int VEC_IQ_ROB_W     = 6;
  localparam int VEC_IQ_PREG_W    = 7;
  localparam int VEC_IQ_PAYLOAD_W = 64;
  localparam int VEC_IQ_NWK       = 2;

  typedef struct packed {
    logic                              valid;
    logic [VEC_IQ_ROB_W-1:0]           rob_idx;
    logic [VEC_IQ_PAYLOAD_W-1:0]       payload;
    logic [1:0][VEC_IQ_PREG_W-1:0]     tag;
    logic [1:0]                        rdy;
  } vec_iq_entry_t;
endpackage

// File: rtl/vec_iq_wakeup_cmp.sv
// Matches one source tag against every wakeup broadcast port.
module vec_iq_wakeup_cmp
  import z480_pkg::*;
#(
  parameter int NWK    = VEC_IQ_NWK,
  parameter int PREG_W = VEC_IQ_PREG_W
) (
  input  logic [PREG_W-1:0]     tag,
  input  logic [NWK-1:0]        wk_valid,
  input  logic [NWK*PREG_W-1:0] wk_tag,
  output logic                  hit
);
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NWK; k++) begin
      if (wk_valid[k] && (wk_tag[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
  end
endmodule

// File: rtl/vec_issue_q.sv
// Compacting out-of-order issue queue for the Z480 vector unit; slot 0 is always the oldest entry.
module vec_issue_q
  import z480_pkg::*;
#(
  parameter int DEPTH     = VEC_IQ_DEPTH,
  parameter int ROB_W     = VEC_IQ_ROB_W,
  parameter int PREG_W    = VEC_IQ_PREG_W,
  parameter int PAYLOAD_W = VEC_IQ_PAYLOAD_W,
  parameter int NWK       = VEC_IQ_NWK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [ROB_W-1:0]           enq_rob_idx,
  input  logic [PAYLOAD_W-1:0]       enq_payload,
  input  logic [2*PREG_W-1:0]        enq_src_tag,
  input  logic [1:0]                 enq_src_rdy,
  input  logic [NWK-1:0]             wk_valid,
  input  logic [NWK*PREG_W-1:0]      wk_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [ROB_W-1:0]           iss_rob_idx,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);

  vec_iq_entry_t q     [DEPTH];
  vec_iq_entry_t woken [DEPTH+1];
  vec_iq_entry_t nxt   [DEPTH];
  vec_iq_entry_t enq_ent;

  logic [DEPTH-1:0][1:0] ent_hit;
  logic [1:0]            enq_hit;
  logic [DEPTH-1:0]      cand;
  logic [DEPTH-1:0]      at_or_above_win;
  logic [DEPTH-1:0]      valid_vec;
  logic                  any_cand;
  logic                  do_iss;
  logic                  do_enq;
  logic [OCC_W-1:0]      enq_pos;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    for (genvar s = 0; s < 2; s++) begin : g_src
      vec_iq_wakeup_cmp #(.NWK(NWK), .PREG_W(PREG_W)) u_cmp (
        .tag      (q[i].tag[s]),
        .wk_valid (wk_valid),
        .wk_tag   (wk_tag),
        .hit      (ent_hit[i][s])
      );
    end
    assign cand[i]      = q[i].valid && q[i].rdy[0] && q[i].rdy[1];
    assign valid_vec[i] = q[i].valid;
  end

  for (genvar s = 0; s < 2; s++) begin : g_enq
    vec_iq_wakeup_cmp #(.NWK(NWK), .PREG_W(PREG_W)) u_cmp (
      .tag      (enq_src_tag[s*PREG_W +: PREG_W]),
      .wk_valid (wk_valid),
      .wk_tag   (wk_tag),
      .hit      (enq_hit[s])
    );
  end

  // Priority select: lowest-index candidate wins; at_or_above_win marks slots that shift on issue.
  always_comb begin
    any_cand        = 1'b0;
    iss_rob_idx     = '0;
    iss_payload     = '0;
    at_or_above_win = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && !any_cand) begin
        any_cand    = 1'b1;
        iss_rob_idx = q[i].rob_idx;
        iss_payload = q[i].payload;
      end
      at_or_above_win[i] = any_cand;
    end
  end

  assign iss_valid = any_cand && !flush;
  assign enq_ready = (occupancy < OCC_W'(DEPTH));
  assign do_iss    = iss_valid && iss_ready;
  assign do_enq    = enq_valid && enq_ready && !flush;
  assign enq_pos   = do_iss ? (occupancy - OCC_W'(1)) : occupancy;

  always_comb begin
    enq_ent         = '0;
    enq_ent.valid   = 1'b1;
    enq_ent.rob_idx = enq_rob_idx;
    enq_ent.payload = enq_payload;
    enq_ent.tag     = enq_src_tag;
    enq_ent.rdy     = enq_src_rdy | enq_hit;
    woken[DEPTH]    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woken[i]     = q[i];
      woken[i].rdy = q[i].rdy | (ent_hit[i] & {2{q[i].valid}});
    end
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = (do_iss && at_or_above_win[i]) ? woken[i+1] : woken[i];
      if (do_enq && (enq_pos == OCC_W'(i))) nxt[i] = enq_ent;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      occupancy <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
      occupancy <= occupancy + OCC_W'(do_enq) - OCC_W'(do_iss);
    end
  end

`ifndef SYNTHESIS
  a_occ_contig: assert property (@(posedge clk) disable iff (rst)
    (occupancy <= OCC_W'(DEPTH)) && ((valid_vec & (valid_vec + DEPTH'(1))) == '0));
`endif
endmodule

// File: tb/tb_vec_issue_q.sv
// Scenario bench for vec_issue_q with an in-order scoreboard of expected issue ROB indices.
module tb_vec_issue_q;
  localparam int DEPTH = 4;
  localparam int ROB_W = 6;
  localparam int PREG_W = 7;
  localparam int PAYLOAD_W = 64;
  localparam int NWK = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic                   enq_valid = 1'b0;
  logic                   enq_ready;
  logic [ROB_W-1:0]       enq_rob_idx = '0;
  logic [PAYLOAD_W-1:0]   enq_payload = '0;
  logic [2*PREG_W-1:0]    enq_src_tag = '0;
  logic [1:0]             enq_src_rdy = '0;
  logic [NWK-1:0]         wk_valid = '0;
  logic [NWK*PREG_W-1:0]  wk_tag = '0;
  logic                   iss_valid;
  logic                   iss_ready = 1'b0;
  logic [ROB_W-1:0]       iss_rob_idx;
  logic [PAYLOAD_W-1:0]   iss_payload;
  logic [2:0]             occupancy;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];
  int exp_rob;

  vec_issue_q #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .NWK(NWK)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rob_idx(enq_rob_idx),
    .enq_payload(enq_payload), .enq_src_tag(enq_src_tag), .enq_src_rdy(enq_src_rdy),
    .wk_valid(wk_valid), .wk_tag(wk_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rob_idx(iss_rob_idx),
    .iss_payload(iss_payload), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [PAYLOAD_W-1:0] pl(input int rob);
    return 64'hC0DE_5A00_0000_0000 | (64'(rob) << 8) | 64'(rob);
  endfunction

  // Sets the enqueue offer; rdy bit s means source s is already ready.
  task automatic offer(input int rob, input logic [6:0] t0, input logic [6:0] t1, input logic [1:0] rdy);
    enq_valid   = 1'b1;
    enq_rob_idx = ROB_W'(rob);
    enq_payload = pl(rob);
    enq_src_tag = {t1, t0};
    enq_src_rdy = rdy;
  endtask

  task automatic pop_exp();
    if (sb.size() > 0) exp_rob = sb.pop_front();
    else exp_rob = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_enq_ready got %b want 1", enq_ready); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL reset_iss_valid got %b want 0", iss_valid); end
    n_cmp++; if (iss_rob_idx !== '0) begin n_err++; $display("FAIL reset_iss_rob got %0d want 0", iss_rob_idx); end
    n_cmp++; if (iss_payload !== '0) begin n_err++; $display("FAIL reset_iss_payload got %h want 0", iss_payload); end
    rst = 1'b0;
  endtask

  task automatic test_ready_enq();
    @(negedge clk);
    offer(5, 7'h01, 7'h02, 2'b11);
    iss_ready = 1'b1;
    sb.push_back(5);
    @(negedge clk);
    enq_valid = 1'b0;
    pop_exp();
    n_cmp++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL ready_enq_valid got %b want 1", iss_valid); end
    n_cmp++; if (iss_rob_idx !== ROB_W'(exp_rob)) begin n_err++; $display("FAIL ready_enq_rob got %0d want %0d", iss_rob_idx, exp_rob); end
    n_cmp++; if (iss_payload !== pl(exp_rob)) begin n_err++; $display("FAIL ready_enq_payload got %h want %h", iss_payload, pl(exp_rob)); end
    @(negedge clk);
    iss_ready = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL ready_enq_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_oldest_ready();
    @(negedge clk);
    offer(1, 7'h10, 7'h11, 2'b10);
    @(negedge clk);
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL oldest_notready_valid got %b want 0", iss_valid); end
    offer(2, 7'h12, 7'h13, 2'b11);
    sb.push_back(2);
    @(negedge clk);
    enq_valid = 1'b0;
    pop_exp();
    n_cmp++; if (iss_rob_idx !== ROB_W'(exp_rob) || iss_valid !== 1'b1) begin n_err++; $display("FAIL oldest_first_rob got %0d/%b want %0d/1", iss_rob_idx, iss_valid, exp_rob); end
    iss_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL oldest_occ1 got %0d want 1", occupancy); end
    wk_valid = 2'b01;
    wk_tag   = {7'h00, 7'h10};
    sb.push_back(1);
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL wake_no_bypass got %b want 0", iss_valid); end
    @(negedge clk);
    wk_valid = 2'b00;
    pop_exp();
    n_cmp++; if (iss_valid !== 1'b1 || iss_rob_idx !== ROB_W'(exp_rob)) begin n_err++; $display("FAIL wake_next_cycle got %0d/%b want %0d/1", iss_rob_idx, iss_valid, exp_rob); end
    @(negedge clk);
    iss_ready = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL oldest_drain_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_wakeup_on_enq();
    @(negedge clk);
    offer(7, 7'h22, 7'h23, 2'b10);
    wk_valid  = 2'b10;
    wk_tag    = {7'h22, 7'h05};
    iss_ready = 1'b1;
    sb.push_back(7);
    @(negedge clk);
    enq_valid = 1'b0;
    wk_valid  = 2'b00;
    pop_exp();
    n_cmp++; if (iss_valid !== 1'b1 || iss_rob_idx !== ROB_W'(exp_rob)) begin n_err++; $display("FAIL enq_wake got %0d/%b want %0d/1", iss_rob_idx, iss_valid, exp_rob); end
    @(negedge clk);
    iss_ready = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL enq_wake_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_full();
    int budget;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      offer(10 + i, 7'(8'h30 + i), 7'h40, 2'b10);
    end
    @(negedge clk);
    enq_valid = 1'b0;
    n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL full_enq_ready got %b want 0", enq_ready); end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ got %0d want 4", occupancy); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL full_none_ready got %b want 0", iss_valid); end
    wk_valid = 2'b01;
    wk_tag   = {7'h00, 7'h32};
    sb.push_back(12);
    @(negedge clk);
    wk_valid = 2'b00;
    pop_exp();
    n_cmp++; if (iss_valid !== 1'b1 || iss_rob_idx !== ROB_W'(exp_rob)) begin n_err++; $display("FAIL full_mid_issue got %0d/%b want %0d/1", iss_rob_idx, iss_valid, exp_rob); end
    iss_ready = 1'b1;
    offer(20, 7'h50, 7'h51, 2'b11);
    n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL full_issue_enq_ready got %b want 0", enq_ready); end
    @(negedge clk);
    iss_ready = 1'b0;
    enq_valid = 1'b0;
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL full_after_issue_occ got %0d want 3", occupancy); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL full_rejected_enq got %b want 0", iss_valid); end
    wk_valid = 2'b11;
    wk_tag   = {7'h31, 7'h30};
    sb.push_back(10);
    sb.push_back(11);
    @(negedge clk);
    wk_valid = 2'b01;
    wk_tag   = {7'h00, 7'h33};
    sb.push_back(13);
    @(negedge clk);
    wk_valid  = 2'b00;
    iss_ready = 1'b1;
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      if (iss_valid === 1'b1) begin
        pop_exp();
        n_cmp++; if (iss_rob_idx !== ROB_W'(exp_rob)) begin n_err++; $display("FAIL full_order got %0d want %0d", iss_rob_idx, exp_rob); end
      end
      @(negedge clk);
      budget++;
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL full_drain_timeout left %0d want 0", sb.size()); sb.delete(); end
    iss_ready = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL full_drain_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    int budget;
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      offer((i == 2) ? 6 : 3 + i, 7'h60, 7'h61, 2'b11);
      sb.push_back((i == 2) ? 6 : 3 + i);
    end
    @(negedge clk);
    enq_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (iss_valid !== 1'b1 || iss_rob_idx !== ROB_W'(sb[0]) || iss_payload !== pl(sb[0])) begin
        n_err++; $display("FAIL bp_stable cyc %0d got %0d/%b want %0d/1", c, iss_rob_idx, iss_valid, sb[0]);
      end
      @(negedge clk);
    end
    iss_ready = 1'b1;
    budget = 0;
    while (sb.size() > 0 && budget < 8) begin
      pop_exp();
      n_cmp++; if (iss_valid !== 1'b1 || iss_rob_idx !== ROB_W'(exp_rob)) begin n_err++; $display("FAIL bp_order got %0d/%b want %0d/1", iss_rob_idx, iss_valid, exp_rob); end
      @(negedge clk);
      budget++;
    end
    iss_ready = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL bp_drain_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      offer((i == 2) ? 15 : 8 + i, 7'h70, 7'h71, 2'b11);
    end
    @(negedge clk);
    enq_valid = 1'b0;
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL flush_pre_occ got %0d want 3", occupancy); end
    flush = 1'b1;
    offer(21, 7'h72, 7'h73, 2'b11);
    iss_ready = 1'b1;
    #1;
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL flush_gates_issue got %b want 0", iss_valid); end
    @(negedge clk);
    flush = 1'b0;
    enq_valid = 1'b0;
    iss_ready = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_enq got %b want 0", iss_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      offer(30 + i, 7'h08, 7'h09, 2'b11);
    end
    @(negedge clk);
    enq_valid = 1'b0;
    n_cmp++; if (occupancy !== 3'd2 || iss_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %0d/%b want 2/1", occupancy, iss_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_iss_valid got %b want 0", iss_valid); end
    n_cmp++; if (enq_ready !== 1'b1 || occupancy !== 3'd0) begin n_err++; $display("FAIL rstmid_empty got %b/%0d want 1/0", enq_ready, occupancy); end
    @(negedge clk);
    rst = 1'b0;
    offer(9, 7'h0A, 7'h0B, 2'b11);
    iss_ready = 1'b1;
    sb.push_back(9);
    @(negedge clk);
    enq_valid = 1'b0;
    pop_exp();
    n_cmp++; if (iss_valid !== 1'b1 || iss_rob_idx !== ROB_W'(exp_rob)) begin n_err++; $display("FAIL rstmid_recover got %0d/%b want %0d/1", iss_rob_idx, iss_valid, exp_rob); end
    @(negedge clk);
    iss_ready = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rstmid_recover_occ got %0d want 0", occupancy); end
  endtask

  initial begin
    test_reset();
    test_ready_enq();
    test_oldest_ready();
    test_wakeup_on_enq();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
